// File: rtl/commit_serializer_if.sv
// commit_serializer_if: shared commit types plus the commit/head handshake bundle.
//   connector_pkg        : XLEN, fu_op and cf_t types used by the commit path
//   commit_serializer_if : commit inputs (valid_i, pc_i, op_i, branch_taken_i, cf_type_i,
//                          exception_i, interrupt_i), head outputs (valid_o, ready_i, pc_o,
//                          op_o, branch_taken_o, cf_type_o, exception_o, interrupt_o) and
//                          status (ready_o, occupancy_o, overflow_o)
//   modport slave  : serializer view
//   modport master : commit source / downstream consumer view
package connector_pkg;
    localparam int XLEN = 32;
    typedef logic [3:0] fu_op;
    typedef logic [2:0] cf_t;
endpackage

interface commit_serializer_if #(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
);
    import connector_pkg::*;
    logic [NRET-1:0]            valid_i;
    logic [NRET-1:0][XLEN-1:0]  pc_i;
    fu_op [NRET-1:0]            op_i;
    logic [NRET-1:0]            branch_taken_i;
    cf_t  [NRET-1:0]            cf_type_i;
    logic                       exception_i;
    logic                       interrupt_i;
    logic                       ready_o;
    logic                       valid_o;
    logic                       ready_i;
    logic [XLEN-1:0]            pc_o;
    fu_op                       op_o;
    logic                       branch_taken_o;
    cf_t                        cf_type_o;
    logic                       exception_o;
    logic                       interrupt_o;
    logic [$clog2(DEPTH):0]     occupancy_o;
    logic                       overflow_o;

    modport slave (
        input  valid_i, pc_i, op_i, branch_taken_i, cf_type_i, exception_i, interrupt_i, ready_i,
        output ready_o, valid_o, pc_o, op_o, branch_taken_o, cf_type_o, exception_o, interrupt_o,
               occupancy_o, overflow_o
    );

    modport master (
        output valid_i, pc_i, op_i, branch_taken_i, cf_type_i, exception_i, interrupt_i, ready_i,
        input  ready_o, valid_o, pc_o, op_o, branch_taken_o, cf_type_o, exception_o, interrupt_o,
               occupancy_o, overflow_o
    );
endinterface

// File: rtl/commit_serializer.sv
// commit_serializer: compacts up to NRET commits plus exception/interrupt events per cycle
// into a circular FIFO and presents them one at a time to the itype detector.
//   clk_i : clock, all state on rising edge
//   rst_i : asynchronous active-high reset
//   bus   : commit_serializer_if.slave (commit inputs, head outputs, ready/occupancy/overflow)
module commit_serializer
    import connector_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    commit_serializer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NC = NRET + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fu_op            op;
        logic            taken;
        cf_t             cf;
        logic            exc;
        logic            intr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    entry_t          cand [NC];
    logic [NC-1:0]   cand_v;
    logic [AW-1:0]   cand_off [NC];
    logic [CW-1:0]   acc;
    logic [CW-1:0]   npush;
    logic            ready, event_any, accept, pop;
    entry_t          head;

    // Candidate slots: port entries in age order, interrupt event last. A port-0 exception
    // without a port-0 commit reuses slot 0 as a standalone event so it stays oldest.
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            cand[i] = '{pc: bus.pc_i[i], op: bus.op_i[i], taken: bus.branch_taken_i[i],
                        cf: bus.cf_type_i[i], exc: 1'b0, intr: 1'b0};
            cand_v[i] = bus.valid_i[i];
        end
        cand[NRET] = '0;
        cand[NRET].intr = 1'b1;
        cand_v[NRET] = bus.interrupt_i;
        cand[0].exc = bus.exception_i;
        if (!bus.valid_i[0]) begin
            cand[0] = '0;
            cand[0].exc = 1'b1;
            cand_v[0] = bus.exception_i;
        end
        acc = '0;
        for (int i = 0; i < NC; i++) begin
            cand_off[i] = acc[AW-1:0];
            acc = acc + CW'(cand_v[i]);
        end
        npush = acc;
    end

    // Reserve room for a worst-case cycle so a cycle is either fully accepted or fully dropped.
    assign ready     = count <= CW'(DEPTH - NC);
    assign event_any = |bus.valid_i | bus.exception_i | bus.interrupt_i;
    assign accept    = ready & event_any;
    assign pop       = (count != '0) & bus.ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (accept) wr_ptr <= wr_ptr + npush[AW-1:0];
            count <= count + (accept ? npush : CW'(0)) - CW'(pop);
            if (event_any && !ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NC; i++)
            if (accept && cand_v[i]) mem[wr_ptr + cand_off[i]] <= cand[i];
    end

    assign head               = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.ready_o        = ready;
    assign bus.valid_o        = count != '0;
    assign bus.pc_o           = head.pc;
    assign bus.op_o           = head.op;
    assign bus.branch_taken_o = head.taken;
    assign bus.cf_type_o      = head.cf;
    assign bus.exception_o    = head.exc;
    assign bus.interrupt_o    = head.intr;
    assign bus.occupancy_o    = count;
    assign bus.overflow_o     = overflow;
endmodule

// File: tb/tb_commit_serializer.sv
// tb_commit_serializer: directed self-checking bench for commit_serializer (NRET=2, DEPTH=8).
module tb_commit_serializer;
    logic clk, rst;
    int   nvec, nerr;

    commit_serializer_if #(.NRET(2), .DEPTH(8)) bus ();
    commit_serializer #(.NRET(2), .DEPTH(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i = '0;
        bus.pc_i = '0;
        bus.op_i = '0;
        bus.branch_taken_i = '0;
        bus.cf_type_i = '0;
        bus.exception_i = 1'b0;
        bus.interrupt_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.ready_i = 1'b0;
        #12;
        nvec++; if (bus.valid_o !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
        nvec++; if (bus.occupancy_o !== 4'd0) begin nerr++; $display("FAIL rst_occ: got %0d want 0", bus.occupancy_o); end
        nvec++; if (bus.ready_o !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", bus.ready_o); end
        nvec++; if (bus.overflow_o !== 1'b0) begin nerr++; $display("FAIL rst_ovf: got %b want 0", bus.overflow_o); end
        nvec++; if (bus.pc_o !== 32'h0) begin nerr++; $display("FAIL rst_pc: got %h want 0", bus.pc_o); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_dual();
        bus.ready_i = 1'b1;
        bus.valid_i = 2'b11;
        bus.pc_i[0] = 32'h100;
        bus.pc_i[1] = 32'h104;
        bus.op_i[0] = 4'd3;
        bus.branch_taken_i = 2'b10;
        bus.cf_type_i[1] = 3'd2;
        step();
        idle();
        nvec++; if (bus.pc_o !== 32'h100) begin nerr++; $display("FAIL dual_pc0: got %h want 100", bus.pc_o); end
        nvec++; if (bus.op_o !== 4'd3) begin nerr++; $display("FAIL dual_op0: got %0d want 3", bus.op_o); end
        nvec++; if (bus.branch_taken_o !== 1'b0) begin nerr++; $display("FAIL dual_tk0: got %b want 0", bus.branch_taken_o); end
        nvec++; if (bus.occupancy_o !== 4'd2) begin nerr++; $display("FAIL dual_occ: got %0d want 2", bus.occupancy_o); end
        step();
        nvec++; if (bus.pc_o !== 32'h104) begin nerr++; $display("FAIL dual_pc1: got %h want 104", bus.pc_o); end
        nvec++; if (bus.branch_taken_o !== 1'b1) begin nerr++; $display("FAIL dual_tk1: got %b want 1", bus.branch_taken_o); end
        nvec++; if (bus.cf_type_o !== 3'd2) begin nerr++; $display("FAIL dual_cf1: got %0d want 2", bus.cf_type_o); end
        step();
        nvec++; if (bus.valid_o !== 1'b0) begin nerr++; $display("FAIL dual_empty: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_compact_exception();
        bus.ready_i = 1'b0;
        bus.valid_i = 2'b10;
        bus.pc_i[1] = 32'h200;
        step();
        idle();
        bus.exception_i = 1'b1;
        nvec++; if (bus.pc_o !== 32'h200) begin nerr++; $display("FAIL cmp_pc: got %h want 200", bus.pc_o); end
        nvec++; if (bus.occupancy_o !== 4'd1) begin nerr++; $display("FAIL cmp_occ1: got %0d want 1", bus.occupancy_o); end
        nvec++; if (bus.exception_o !== 1'b0) begin nerr++; $display("FAIL cmp_exc0: got %b want 0", bus.exception_o); end
        step();
        idle();
        nvec++; if (bus.occupancy_o !== 4'd2) begin nerr++; $display("FAIL cmp_occ2: got %0d want 2", bus.occupancy_o); end
        bus.ready_i = 1'b1;
        step();
        nvec++; if (bus.exception_o !== 1'b1) begin nerr++; $display("FAIL cmp_exc_evt: got %b want 1", bus.exception_o); end
        nvec++; if (bus.pc_o !== 32'h0) begin nerr++; $display("FAIL cmp_evt_pc: got %h want 0", bus.pc_o); end
        nvec++; if (bus.valid_o !== 1'b1) begin nerr++; $display("FAIL cmp_evt_valid: got %b want 1", bus.valid_o); end
        step();
        nvec++; if (bus.valid_o !== 1'b0) begin nerr++; $display("FAIL cmp_empty: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_interrupt();
        bus.ready_i = 1'b0;
        bus.valid_i = 2'b01;
        bus.pc_i[0] = 32'h300;
        bus.exception_i = 1'b1;
        bus.interrupt_i = 1'b1;
        step();
        idle();
        nvec++; if (bus.occupancy_o !== 4'd2) begin nerr++; $display("FAIL int_occ: got %0d want 2", bus.occupancy_o); end
        nvec++; if (bus.pc_o !== 32'h300 || bus.exception_o !== 1'b1 || bus.interrupt_o !== 1'b0) begin
            nerr++; $display("FAIL int_head0: got pc=%h exc=%b int=%b want pc=300 exc=1 int=0", bus.pc_o, bus.exception_o, bus.interrupt_o);
        end
        bus.ready_i = 1'b1;
        step();
        nvec++; if (bus.pc_o !== 32'h0 || bus.exception_o !== 1'b0 || bus.interrupt_o !== 1'b1) begin
            nerr++; $display("FAIL int_head1: got pc=%h exc=%b int=%b want pc=0 exc=0 int=1", bus.pc_o, bus.exception_o, bus.interrupt_o);
        end
        step();
        nvec++; if (bus.valid_o !== 1'b0) begin nerr++; $display("FAIL int_empty: got %b want 0", bus.valid_o); end
        bus.ready_i = 1'b0;
        bus.valid_i = 2'b10;
        bus.pc_i[1] = 32'h400;
        bus.exception_i = 1'b1;
        bus.interrupt_i = 1'b1;
        step();
        idle();
        nvec++; if (bus.occupancy_o !== 4'd3) begin nerr++; $display("FAIL int3_occ: got %0d want 3", bus.occupancy_o); end
        nvec++; if (bus.pc_o !== 32'h0 || bus.exception_o !== 1'b1) begin
            nerr++; $display("FAIL int3_h0: got pc=%h exc=%b want pc=0 exc=1", bus.pc_o, bus.exception_o);
        end
        bus.ready_i = 1'b1;
        step();
        nvec++; if (bus.pc_o !== 32'h400 || bus.exception_o !== 1'b0 || bus.interrupt_o !== 1'b0) begin
            nerr++; $display("FAIL int3_h1: got pc=%h exc=%b int=%b want pc=400 exc=0 int=0", bus.pc_o, bus.exception_o, bus.interrupt_o);
        end
        step();
        nvec++; if (bus.interrupt_o !== 1'b1 || bus.pc_o !== 32'h0) begin
            nerr++; $display("FAIL int3_h2: got pc=%h int=%b want pc=0 int=1", bus.pc_o, bus.interrupt_o);
        end
        step();
        nvec++; if (bus.valid_o !== 1'b0) begin nerr++; $display("FAIL int3_empty: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_backpressure();
        bus.ready_i = 1'b0;
        bus.valid_i = 2'b01;
        bus.pc_i[0] = 32'h600;
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            nvec++; if (bus.pc_o !== 32'h600 || bus.valid_o !== 1'b1) begin
                nerr++; $display("FAIL bp_hold%0d: got pc=%h v=%b want pc=600 v=1", k, bus.pc_o, bus.valid_o);
            end
            step();
        end
        bus.ready_i = 1'b1;
        step();
        nvec++; if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 4'd0) begin
            nerr++; $display("FAIL bp_pop: got v=%b occ=%0d want v=0 occ=0", bus.valid_o, bus.occupancy_o);
        end
    endtask

    task automatic test_wrap();
        bus.ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.valid_i = 2'b01;
            bus.pc_i[0] = 32'h1000 + 32'(4 * k);
            step();
            nvec++; if (bus.pc_o !== 32'h1000 + 32'(4 * k) || bus.valid_o !== 1'b1) begin
                nerr++; $display("FAIL wrap_pc%0d: got pc=%h v=%b want pc=%h v=1", k, bus.pc_o, bus.valid_o, 32'h1000 + 32'(4 * k));
            end
            nvec++; if (bus.occupancy_o > 4'd1) begin nerr++; $display("FAIL wrap_occ%0d: got %0d want <=1", k, bus.occupancy_o); end
        end
        idle();
        step();
        nvec++; if (bus.valid_o !== 1'b0) begin nerr++; $display("FAIL wrap_empty: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_fill_overflow();
        bus.ready_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.valid_i = 2'b11;
            bus.pc_i[0] = 32'(16 * k);
            bus.pc_i[1] = 32'(16 * k + 4);
            step();
            nvec++; if (bus.occupancy_o !== 4'(2 * k)) begin nerr++; $display("FAIL fill_occ%0d: got %0d want %0d", k, bus.occupancy_o, 2 * k); end
            nvec++; if (bus.ready_o !== (k < 3)) begin nerr++; $display("FAIL fill_ready%0d: got %b want %b", k, bus.ready_o, k < 3); end
        end
        nvec++; if (bus.overflow_o !== 1'b0) begin nerr++; $display("FAIL fill_noovf: got %b want 0", bus.overflow_o); end
        bus.pc_i[0] = 32'hdead;
        step();
        idle();
        nvec++; if (bus.occupancy_o !== 4'd6) begin nerr++; $display("FAIL ovf_occ: got %0d want 6", bus.occupancy_o); end
        nvec++; if (bus.overflow_o !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", bus.overflow_o); end
        step();
        nvec++; if (bus.overflow_o !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
        nvec++; if (bus.pc_o !== 32'h10) begin nerr++; $display("FAIL ovf_head: got %h want 10", bus.pc_o); end
    endtask

    task automatic test_mid_reset();
        bus.ready_i = 1'b1;
        step();
        bus.ready_i = 1'b0;
        nvec++; if (bus.occupancy_o !== 4'd5) begin nerr++; $display("FAIL mr_occ5: got %0d want 5", bus.occupancy_o); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (bus.valid_o !== 1'b0 || bus.occupancy_o !== 4'd0) begin
            nerr++; $display("FAIL mr_async: got v=%b occ=%0d want v=0 occ=0", bus.valid_o, bus.occupancy_o);
        end
        nvec++; if (bus.overflow_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            nerr++; $display("FAIL mr_flags: got ovf=%b rdy=%b want ovf=0 rdy=1", bus.overflow_o, bus.ready_o);
        end
        #2 rst = 1'b0;
        bus.valid_i = 2'b01;
        bus.pc_i[0] = 32'h500;
        step();
        idle();
        nvec++; if (bus.pc_o !== 32'h500 || bus.occupancy_o !== 4'd1) begin
            nerr++; $display("FAIL mr_push: got pc=%h occ=%0d want pc=500 occ=1", bus.pc_o, bus.occupancy_o);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_dual();
        test_compact_exception();
        test_interrupt();
        test_backpressure();
        test_wrap();
        test_fill_overflow();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/commit_serializer.md
COMMIT_SERIALIZER -- requirements
Module: commit_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2, meaning number of commit ports sampled per cycle (legal values 1..2).
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of FIFO entries (power of two, at least 2*(NRET+1)).
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  NRET  commit valid per port; port 0 is oldest.
- pc_i  in  NRET x connector_pkg::XLEN  committed PC per port.
- op_i  in  NRET x connector_pkg::fu_op  functional-unit op per port.
- branch_taken_i  in  NRET  branch/jump resolved taken per port.
- cf_type_i  in  NRET x connector_pkg::cf_t  control-flow type per port.
- exception_i  in  1  exception this cycle; belongs to port 0.
- interrupt_i  in  1  interrupt this cycle.
- ready_o  out  1  space available for one full commit cycle.
- valid_o  out  1  head entry valid toward the itype detector.
- ready_i  in  1  downstream accepts head entry.
- pc_o  out  connector_pkg::XLEN  head PC.
- op_o  out  connector_pkg::fu_op  head op.
- branch_taken_o  out  1  head taken flag.
- cf_type_o  out  connector_pkg::cf_t  head control-flow type.
- exception_o  out  1  head carries an exception.
- interrupt_o  out  1  head is an interrupt event.
- occupancy_o  out  $clog2(DEPTH)+1  entries currently stored.
- overflow_o  out  1  sticky: a commit was lost.

Function
REQ-004 SHALL store entries {pc, op, branch_taken, cf_type, exception, interrupt} in a circular FIFO with read pointer, write pointer and count; both pointers wrap modulo DEPTH.
REQ-005 SHALL push, in one cycle, one entry per set valid_i bit, in ascending port order, compacted into consecutive slots (valid_i=2'b10 writes exactly one entry, from port 1).
REQ-006 SHALL set the exception flag on the port 0 entry when exception_i and valid_i[0] are both 1.
REQ-007 SHALL push a standalone event entry (pc=0, op=0, cf_type=0, exception=1) when exception_i=1 and valid_i[0]=0.
REQ-008 SHALL push a standalone event entry (interrupt=1, other fields 0) when interrupt_i=1, placed after all instruction entries of the same cycle.
REQ-009 SHALL drive ready_o = 1 exactly when DEPTH - count >= NRET+1, computed combinationally from the registered count.
REQ-010 SHALL, when any input event is present while ready_o=0, drop every entry of that cycle, leave the FIFO unchanged and set overflow_o=1 from the next cycle until reset.
REQ-011 SHALL drive valid_o = (count != 0) and the head fields from the entry at the read pointer; all head fields SHALL be 0 while count=0.
REQ-012 SHALL pop one entry per cycle when valid_o=1 and ready_i=1, advancing the read pointer by 1.
REQ-013 SHALL hold the head fields stable while valid_o=1 and ready_i=0.
REQ-014 SHALL make a pushed entry visible at the outputs no earlier than the cycle after the push; there is no input-to-output combinational path.
REQ-015 SHALL allow push and pop in the same cycle; next count = count + pushes - pop, always between 0 and DEPTH.
REQ-016 SHALL NOT pop when count=0, regardless of ready_i.
REQ-017 SHALL drive occupancy_o equal to the registered count.

Reset
REQ-018 SHALL, while rst_i=1 (asynchronously), clear pointers, count and overflow_o; valid_o=0, all head fields 0, occupancy_o=0, ready_o=1.
REQ-019 SHALL discard all stored entries when rst_i is asserted mid-operation; the first push after deassertion goes to slot 0.

Verification
REQ-020 Dual commit: valid_i=2'b11, pc_i={0x104,0x100}, ready_i=1 -> next cycle pc_o=0x100; following cycle pc_o=0x104; then valid_o=0.
REQ-021 Compaction and exception: valid_i=2'b10 with pc_i[1]=0x200, then the next cycle valid_i=0 with exception_i=1 -> output sequence pc=0x200, then an event with exception_o=1 and pc_o=0; occupancy_o peaks at 2.
REQ-022 Fill/overflow (DEPTH=8, NRET=2, ready_i=0): push 2 per cycle -> ready_o falls when occupancy_o=6; a further push with ready_o=0 leaves occupancy_o=6 and sets overflow_o=1, which stays 1.
REQ-023 Backpressure: hold ready_i=0 for 3 cycles with 1 entry stored -> pc_o constant and valid_o=1; raise ready_i -> pop in that cycle.
REQ-024 Wrap-around and simultaneous push/pop: stream 20 single commits with ready_i=1 -> order preserved across pointer wrap; occupancy_o never exceeds 1.
REQ-025 Mid-operation reset: assert rst_i asynchronously with 5 entries stored -> valid_o=0 and occupancy_o=0 immediately; overflow_o=0.
